// File: rtl/bwt_pkg.sv
// BWT register map, bit positions, response code and state encodings
// shared by the AXI4-Lite sequencer and its transaction engine.
package bwt_pkg;

  localparam logic [3:0] BWT_OFF_CTRL   = 4'h0;
  localparam logic [3:0] BWT_OFF_LEN    = 4'h4;
  localparam logic [3:0] BWT_OFF_STATUS = 4'h8;
  localparam logic [3:0] BWT_OFF_RESULT = 4'hC;

  localparam int BWT_CTRL_START_BIT  = 0;
  localparam int BWT_STATUS_DONE_BIT = 0;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_CTRL,
    S_RD_STAT,
    S_RD_RES,
    S_FINISH
  } bwt_state_t;

  typedef enum logic [2:0] {
    X_IDLE,
    X_WR,
    X_B,
    X_AR,
    X_R
  } xfer_state_t;

  function automatic logic [31:0] ctrl_start_word();
    return 32'd1 << BWT_CTRL_START_BIT;
  endfunction

endpackage

// File: rtl/bwt_axil_xfer.sv
// Single-transaction AXI4-Lite master engine: one read or write at a time,
// ack pulses on the B or R handshake with the response error flag.
module bwt_axil_xfer
  import bwt_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [2:0]          axi_awprot,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [2:0]          axi_arprot,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready
);

  xfer_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_pend;
  logic              w_pend;
  logic              launch;

  assign aw_pend = axi_awvalid & ~axi_awready;
  assign w_pend  = axi_wvalid & ~axi_wready;

  assign ack = (state == X_B && axi_bvalid)
            || (state == X_R && axi_rvalid);
  assign err = (state == X_B)
             ? (axi_bresp != AXI_RESP_OKAY)
             : (axi_rresp != AXI_RESP_OKAY);
  assign rdata = axi_rdata;

  // A new request may start in the cycle the previous one completes.
  assign launch = req && (state == X_IDLE || ack);

  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = '1;
  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= X_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else if (launch) begin
      addr_q     <= addr;
      wdata_q    <= wdata;
      axi_bready <= 1'b0;
      axi_rready <= 1'b0;
      if (we) begin
        axi_awvalid <= 1'b1;
        axi_wvalid  <= 1'b1;
        state       <= X_WR;
      end else begin
        axi_arvalid <= 1'b1;
        state       <= X_AR;
      end
    end else begin
      unique case (state)
        X_IDLE: ;
        X_WR: begin
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready)  axi_wvalid  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            axi_bready <= 1'b1;
            state      <= X_B;
          end
        end
        X_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            state      <= X_IDLE;
          end
        end
        X_AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= X_R;
          end
        end
        X_R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            state      <= X_IDLE;
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bwt_axil_sequencer.sv
// Runs one BWT transform over AXI4-Lite: program LEN, kick CTRL,
// poll STATUS until done or timeout, then fetch RESULT.
module bwt_axil_sequencer
  import bwt_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_POLL_LIMIT = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start_i,
  input  logic [31:0]                     len_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [31:0]                     result_o,
  output logic                            err_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  bwt_state_t state;
  logic [31:0] poll_cnt;
  logic        poll_last;
  logic        stat_done;

  logic          x_req;
  logic          x_we;
  logic [3:0]    x_off;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          x_ack;
  logic [DW-1:0] x_rdata;
  logic          x_err;

  assign poll_last = (poll_cnt + 32'd1) == 32'(C_POLL_LIMIT);
  assign stat_done = x_rdata[BWT_STATUS_DONE_BIT];
  assign x_addr    = C_BASE_ADDR + {{(AW-4){1'b0}}, x_off};

  // Next transaction is issued on the edge the current one completes.
  always_comb begin
    x_req   = 1'b0;
    x_we    = 1'b0;
    x_off   = BWT_OFF_LEN;
    x_wdata = '0;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          x_req   = 1'b1;
          x_we    = 1'b1;
          x_off   = BWT_OFF_LEN;
          x_wdata = len_i;
        end
      end
      S_WR_LEN: begin
        if (x_ack && !x_err) begin
          x_req   = 1'b1;
          x_we    = 1'b1;
          x_off   = BWT_OFF_CTRL;
          x_wdata = ctrl_start_word();
        end
      end
      S_WR_CTRL: begin
        if (x_ack && !x_err) begin
          x_req = 1'b1;
          x_off = BWT_OFF_STATUS;
        end
      end
      S_RD_STAT: begin
        if (x_ack && !x_err) begin
          if (stat_done) begin
            x_req = 1'b1;
            x_off = BWT_OFF_RESULT;
          end else if (!poll_last) begin
            x_req = 1'b1;
            x_off = BWT_OFF_STATUS;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= S_IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      result_o <= '0;
      poll_cnt <= '0;
    end else begin
      done_o <= 1'b0;
      if (x_ack && x_err) begin
        state  <= S_FINISH;
        busy_o <= 1'b0;
        done_o <= 1'b1;
        err_o  <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_i) begin
              state    <= S_WR_LEN;
              busy_o   <= 1'b1;
              err_o    <= 1'b0;
              poll_cnt <= '0;
            end
          end
          S_WR_LEN: begin
            if (x_ack) state <= S_WR_CTRL;
          end
          S_WR_CTRL: begin
            if (x_ack) state <= S_RD_STAT;
          end
          S_RD_STAT: begin
            if (x_ack) begin
              if (stat_done) begin
                state <= S_RD_RES;
              end else begin
                poll_cnt <= poll_cnt + 32'd1;
                if (poll_last) begin
                  state  <= S_FINISH;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  err_o  <= 1'b1;
                end
              end
            end
          end
          S_RD_RES: begin
            if (x_ack) begin
              result_o <= x_rdata;
              state    <= S_FINISH;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              err_o    <= 1'b0;
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  bwt_axil_xfer #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_xfer (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .req         (x_req),
    .we          (x_we),
    .addr        (x_addr),
    .wdata       (x_wdata),
    .ack         (x_ack),
    .rdata       (x_rdata),
    .err         (x_err),
    .axi_awaddr  (M_AXI_AWADDR),
    .axi_awprot  (M_AXI_AWPROT),
    .axi_awvalid (M_AXI_AWVALID),
    .axi_awready (M_AXI_AWREADY),
    .axi_wdata   (M_AXI_WDATA),
    .axi_wstrb   (M_AXI_WSTRB),
    .axi_wvalid  (M_AXI_WVALID),
    .axi_wready  (M_AXI_WREADY),
    .axi_bresp   (M_AXI_BRESP),
    .axi_bvalid  (M_AXI_BVALID),
    .axi_bready  (M_AXI_BREADY),
    .axi_araddr  (M_AXI_ARADDR),
    .axi_arprot  (M_AXI_ARPROT),
    .axi_arvalid (M_AXI_ARVALID),
    .axi_arready (M_AXI_ARREADY),
    .axi_rdata   (M_AXI_RDATA),
    .axi_rresp   (M_AXI_RRESP),
    .axi_rvalid  (M_AXI_RVALID),
    .axi_rready  (M_AXI_RREADY)
  );

endmodule

// File: tb/tb_bwt_axil_sequencer.sv
// Scoreboard bench: directed runs push expected bus events, a monitor
// pops and compares them as the DUT's AXI traffic and done pulses appear.
module tb_bwt_axil_sequencer;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_DONE} ev_kind_t;

  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  avc;
    logic [7:0]  wvc;
    logic        proto;
  } ev_t;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] result_o;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0;
  logic        M_AXI_WREADY = 1'b0;
  logic        M_AXI_BVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_ARREADY = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = '0;

  int vectors = 0;
  int miscompares = 0;
  ev_t exp_q[$];

  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  bresp_q[$];
  logic [31:0] status_q[$];
  logic [31:0] stuck_status = '0;
  logic [31:0] result_val = '0;

  always #5 ACLK = ~ACLK;

  bwt_axil_sequencer #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_BASE_ADDR        (32'h0000_0000),
    .C_POLL_LIMIT       (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start_i       (start_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .err_o         (err_o),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  function automatic ev_t mk(input ev_kind_t k,
                             input logic [31:0] a,
                             input logic [31:0] d,
                             input int ac,
                             input int wc,
                             input logic p);
    ev_t e;
    e.kind  = k;
    e.addr  = a;
    e.data  = d;
    e.avc   = 8'(ac);
    e.wvc   = 8'(wc);
    e.proto = p;
    return e;
  endfunction

  task automatic check_ev(input ev_t got);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got a=%h d=%h, required none",
               got.kind.name(), got.addr, got.data);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        miscompares++;
        $display({"FAIL ev_%s: got k=%s a=%h d=%h avc=%0d wvc=%0d p=%0b,",
                  " required k=%s a=%h d=%h avc=%0d wvc=%0d p=%0b"},
                 e.kind.name(), got.kind.name(), got.addr, got.data,
                 got.avc, got.wvc, got.proto, e.kind.name(), e.addr,
                 e.data, e.avc, e.wvc, e.proto);
      end
    end
  endtask

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", n, got, exp);
    end
  endtask

  // Slave model
  logic        s_hs_aw, s_hs_w, s_hs_b, s_hs_ar, s_hs_r;
  logic        got_aw = 1'b0, got_w = 1'b0;
  logic [31:0] s_araddr;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

  initial begin : slave
    forever begin
      @(negedge ACLK);
      s_hs_aw  = M_AXI_AWVALID && M_AXI_AWREADY;
      s_hs_w   = M_AXI_WVALID && M_AXI_WREADY;
      s_hs_b   = M_AXI_BVALID && M_AXI_BREADY;
      s_hs_ar  = M_AXI_ARVALID && M_AXI_ARREADY;
      s_hs_r   = M_AXI_RVALID && M_AXI_RREADY;
      s_araddr = M_AXI_ARADDR;
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        got_aw = 1'b0;
        got_w  = 1'b0;
        aw_cnt = 0;
        w_cnt  = 0;
        ar_cnt = 0;
        continue;
      end
      if (s_hs_aw) got_aw = 1'b1;
      if (s_hs_w)  got_w  = 1'b1;
      if (s_hs_b) begin
        M_AXI_BVALID = 1'b0;
        got_aw = 1'b0;
        got_w  = 1'b0;
      end else if (got_aw && got_w && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
      end
      if (s_hs_r) M_AXI_RVALID = 1'b0;
      if (s_hs_ar) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RRESP  = 2'b00;
        if (s_araddr[3:0] == 4'h8)
          M_AXI_RDATA = (status_q.size() != 0) ? status_q.pop_front()
                                               : stuck_status;
        else
          M_AXI_RDATA = result_val;
      end
      if (M_AXI_AWVALID) begin
        M_AXI_AWREADY = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        M_AXI_AWREADY = 1'b0;
        aw_cnt = 0;
      end
      if (M_AXI_WVALID) begin
        M_AXI_WREADY = (w_cnt >= w_delay);
        w_cnt++;
      end else begin
        M_AXI_WREADY = 1'b0;
        w_cnt = 0;
      end
      if (M_AXI_ARVALID) begin
        M_AXI_ARREADY = (ar_cnt >= ar_delay);
        ar_cnt++;
      end else begin
        M_AXI_ARREADY = 1'b0;
        ar_cnt = 0;
      end
    end
  end

  // Monitor
  int          m_avc = 0, m_wvc = 0, m_arc = 0;
  logic        m_proto = 1'b0;
  logic        aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
  logic [31:0] aw_hold_a, w_hold_d, ar_hold_a;
  logic [31:0] cap_aw = '0, cap_w = '0;

  initial begin : monitor
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        m_avc = 0;
        m_wvc = 0;
        m_arc = 0;
        m_proto = 1'b0;
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        ar_hold = 1'b0;
        continue;
      end
      if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) m_proto = 1'b1;
      if ((M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)
          && (M_AXI_ARVALID || M_AXI_RREADY)) m_proto = 1'b1;
      if (M_AXI_WSTRB !== 4'hF || M_AXI_AWPROT !== 3'b000
          || M_AXI_ARPROT !== 3'b000) m_proto = 1'b1;
      if (aw_hold && (!M_AXI_AWVALID || M_AXI_AWADDR !== aw_hold_a))
        m_proto = 1'b1;
      if (w_hold && (!M_AXI_WVALID || M_AXI_WDATA !== w_hold_d))
        m_proto = 1'b1;
      if (ar_hold && (!M_AXI_ARVALID || M_AXI_ARADDR !== ar_hold_a))
        m_proto = 1'b1;
      if (M_AXI_AWVALID) m_avc++;
      if (M_AXI_WVALID)  m_wvc++;
      if (M_AXI_ARVALID) m_arc++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) cap_aw = M_AXI_AWADDR;
      if (M_AXI_WVALID && M_AXI_WREADY)   cap_w  = M_AXI_WDATA;
      aw_hold   = M_AXI_AWVALID && !M_AXI_AWREADY;
      aw_hold_a = M_AXI_AWADDR;
      w_hold    = M_AXI_WVALID && !M_AXI_WREADY;
      w_hold_d  = M_AXI_WDATA;
      ar_hold   = M_AXI_ARVALID && !M_AXI_ARREADY;
      ar_hold_a = M_AXI_ARADDR;
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        check_ev(mk(EV_WR, cap_aw, cap_w, m_avc, m_wvc, m_proto));
        m_avc = 0;
        m_wvc = 0;
        m_proto = 1'b0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        check_ev(mk(EV_RD, M_AXI_ARADDR, 32'h0, m_arc, 0, m_proto));
        m_arc = 0;
        m_proto = 1'b0;
      end
      if (done_o) begin
        check_ev(mk(EV_DONE, {31'b0, err_o}, result_o, 0, 0,
                    m_proto | busy_o));
        m_proto = 1'b0;
      end
    end
  end

  task automatic run_start(input logic [31:0] len);
    @(posedge ACLK);
    #1;
    start_i = 1'b1;
    len_i   = len;
    @(posedge ACLK);
    #1;
    start_i = 1'b0;
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge ACLK);
      k++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d events pending required 0",
               n, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge ACLK);
  endtask

  task automatic push_std(input logic [31:0] len,
                          input int aw_cyc,
                          input int n_stat,
                          input logic [31:0] res);
    exp_q.push_back(mk(EV_WR, 32'h4, len, aw_cyc, 1, 1'b0));
    exp_q.push_back(mk(EV_WR, 32'h0, 32'h1, aw_cyc, 1, 1'b0));
    for (int i = 0; i < n_stat; i++)
      exp_q.push_back(mk(EV_RD, 32'h8, 32'h0, 1, 0, 1'b0));
    exp_q.push_back(mk(EV_RD, 32'hC, 32'h0, 1, 0, 1'b0));
    exp_q.push_back(mk(EV_DONE, 32'h0, res, 0, 0, 1'b0));
  endtask

  initial begin : stim
    int n;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_ctl",
        {24'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
         M_AXI_RREADY, busy_o, done_o, err_o}, 32'h0);
    chk("reset_result", result_o, 32'h0);
    #2 ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);

    // zero-wait slave, STATUS done on first read
    status_q.push_back(32'h1);
    result_val = 32'h0000_ABCD;
    push_std(32'h10, 1, 1, 32'h0000_ABCD);
    run_start(32'h10);
    chk("busy_after_start", {31'h0, busy_o}, 32'h1);
    drain("zero_wait");
    chk("result_hold", result_o, 32'h0000_ABCD);

    // AWREADY delayed three cycles, WREADY immediate
    aw_delay = 3;
    status_q.push_back(32'h1);
    result_val = 32'h0000_1234;
    push_std(32'h20, 4, 1, 32'h0000_1234);
    run_start(32'h20);
    drain("aw_delay");
    aw_delay = 0;

    // STATUS not done three times
    status_q.push_back(32'h0);
    status_q.push_back(32'h0);
    status_q.push_back(32'h0);
    status_q.push_back(32'h1);
    result_val = 32'h5555_AAAA;
    push_std(32'h7, 1, 4, 32'h5555_AAAA);
    run_start(32'h7);
    drain("poll3");

    // STATUS stuck at 0: poll limit of 4
    stuck_status = 32'h0;
    exp_q.push_back(mk(EV_WR, 32'h4, 32'h3, 1, 1, 1'b0));
    exp_q.push_back(mk(EV_WR, 32'h0, 32'h1, 1, 1, 1'b0));
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(EV_RD, 32'h8, 32'h0, 1, 0, 1'b0));
    exp_q.push_back(mk(EV_DONE, 32'h1, 32'h5555_AAAA, 0, 0, 1'b0));
    run_start(32'h3);
    drain("poll_timeout");

    // SLVERR on the LEN write
    bresp_q.push_back(2'b10);
    exp_q.push_back(mk(EV_WR, 32'h4, 32'h9, 1, 1, 1'b0));
    exp_q.push_back(mk(EV_DONE, 32'h1, 32'h5555_AAAA, 0, 0, 1'b0));
    run_start(32'h9);
    drain("bresp_err");

    // start while busy, then reset with ARVALID pending
    ar_delay = 1000;
    exp_q.push_back(mk(EV_WR, 32'h4, 32'h5, 1, 1, 1'b0));
    exp_q.push_back(mk(EV_WR, 32'h0, 32'h1, 1, 1, 1'b0));
    run_start(32'h5);
    n = 0;
    while (!M_AXI_ARVALID && n < 100) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    chk("arvalid_pending", {31'h0, M_AXI_ARVALID}, 32'h1);
    start_i = 1'b1;
    len_i   = 32'h77;
    @(posedge ACLK);
    #1;
    start_i = 1'b0;
    chk("start_ignored", {30'h0, busy_o, M_AXI_ARVALID}, 32'h3);
    repeat (2) @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    chk("async_drop",
        {24'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
         M_AXI_RREADY, busy_o, done_o, err_o}, 32'h0);
    chk("reset_result_mid", result_o, 32'h0);
    repeat (2) @(posedge ACLK);
    #3;
    ar_delay = 0;
    ARESETN = 1'b1;
    repeat (20) @(posedge ACLK);
    #1;
    chk("no_resume",
        {29'h0, M_AXI_AWVALID, M_AXI_ARVALID, busy_o}, 32'h0);
    drain("reset_abort");

    // clean run after reset
    status_q.push_back(32'h1);
    result_val = 32'h0000_CAFE;
    push_std(32'h40, 1, 1, 32'h0000_CAFE);
    run_start(32'h40);
    drain("after_reset");
    chk("final_idle", {31'h0, busy_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bwt_axil_sequencer.md
BWT_AXIL_SEQUENCER -- requirements
Module: bwt_axil_sequencer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-003 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, base address of the BWT register block.
REQ-004 SHALL have parameter C_POLL_LIMIT, default 1024, maximum number of STATUS reads before timeout.
REQ-005 SHALL have port ACLK, in, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port ARESETN, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port start_i, in, 1, single-cycle request to run one transform.
REQ-008 SHALL have port len_i, in, 32, transform length; sampled when start_i is accepted.
REQ-009 SHALL have port busy_o, out, 1, high from start acceptance until done_o.
REQ-010 SHALL have port done_o, out, 1, one-cycle completion pulse.
REQ-011 SHALL have port result_o, out, 32, last RESULT value read; held until the next run's RESULT read.
REQ-012 SHALL have port err_o, out, 1, valid with done_o: bad response or poll timeout.
REQ-013 SHALL have AW channel ports M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
REQ-014 SHALL have W channel ports M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-015 SHALL have B channel ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
REQ-016 SHALL have AR channel ports M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
REQ-017 SHALL have R channel ports M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-018 SHALL use this register map: CTRL = BASE+0x0 (bit0 start), LEN = BASE+0x4, STATUS = BASE+0x8 (bit0 done), RESULT = BASE+0xC.
REQ-019 SHALL implement states IDLE -> WR_LEN -> WR_CTRL -> RD_STAT -> RD_RES -> FINISH -> IDLE.
REQ-020 SHALL accept start_i only in IDLE; start_i while busy_o is high SHALL be ignored.
REQ-021 SHALL, in WR_LEN, write the captured len_i to LEN; in WR_CTRL, write 32'h1 to CTRL.
REQ-022 SHALL drive WSTRB 4'hF and AWPROT/ARPROT 3'b000 at all times.
REQ-023 SHALL, for each write, assert AWVALID and WVALID together in the state's first cycle and drop each independently after its own handshake.
REQ-024 SHALL hold address and data stable while the corresponding VALID is high.
REQ-025 SHALL assert BREADY once both AW and W have completed, and advance state on the BVALID&BREADY cycle.
REQ-026 SHALL, for each read, assert ARVALID until ARREADY, then assert RREADY, capturing RDATA on the RVALID&RREADY cycle.
REQ-027 SHALL, in RD_STAT, leave for RD_RES when RDATA[0]=1; otherwise reissue the read and increment the poll counter.
REQ-028 SHALL go to FINISH with err_o=1 and skip RD_RES when the poll counter reaches C_POLL_LIMIT.
REQ-029 SHALL, on any BRESP or RRESP ≠ 2'b00, go directly to FINISH with err_o=1; result_o SHALL remain unchanged.
REQ-030 SHALL, in FINISH, pulse done_o for one cycle; busy_o SHALL fall in the same cycle.
REQ-031 SHALL never have more than one outstanding transaction.

Reset
REQ-032 SHALL, while ARESETN=0: state IDLE; all VALID/READY outputs 0; busy_o, done_o, err_o 0; result_o 0; poll counter 0.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction immediately; no resumption after reset release.

Structure
REQ-034 SHALL place register offsets, STATUS/CTRL bit indices, the state enum and the OKAY response code in shared package bwt_pkg.
REQ-035 SHALL factor the single-transaction AXI4-Lite engine into sub-module bwt_axil_xfer (req/we/addr/wdata in; ack/rdata/err out).

Verification
REQ-036 SHALL cover: zero-wait slave, len_i=16, STATUS done on first read, RESULT=0xABCD -> writes LEN=0x10 then CTRL=0x1; one AR to 0x8 and one to 0xC; done_o pulse; result_o=0xABCD; err_o=0.
REQ-037 SHALL cover: AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle; AWVALID held with stable address; BREADY asserted only after both handshakes.
REQ-038 SHALL cover: STATUS returns 0 three times, then 1 -> exactly 4 reads to 0x8, then 1 read to 0xC.
REQ-039 SHALL cover: C_POLL_LIMIT=4 with STATUS stuck at 0 -> 4 STATUS reads, no RESULT read, done_o with err_o=1.
REQ-040 SHALL cover: BRESP=SLVERR on the LEN write -> no CTRL write; done_o with err_o=1; result_o unchanged.
REQ-041 SHALL cover: ARESETN low while ARVALID is high, and start_i pulsed while busy -> VALIDs drop asynchronously; state IDLE; second start_i has no effect.
